// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: types and constants shared by the load/store unit.
//   lsu_size_t  - access size encoding carried on req_size
//   lsu_state_t - LSU sequencing states
//   DM_AW_DEF   - default dm word-address width
//   lsu_misaligned() - size/alignment legality check
package mem_lsu_pkg;

   localparam int DM_AW_DEF = 7;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} lsu_size_t;
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP}          lsu_state_t;

   function automatic logic lsu_misaligned(input lsu_size_t sz, input logic [1:0] off);
      case (sz)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return |off;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational little-endian lane handling for the LSU.
//   word_i    - word read from dm
//   wdata_i   - right-justified store data
//   off_i     - byte offset within the word (addr[1:0])
//   size_i    - access size
//   sgn_i     - sign-extend loads (byte/half only)
//   ld_data_o - extracted and extended load data
//   st_word_o - word_i with the store lane replaced by wdata_i
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  off_i,
   input  lsu_size_t   size_i,
   input  logic        sgn_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (off_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      ld_data_o = '0;
      st_word_o = word_i;
      case (size_i)
         SZ_BYTE: begin
            ld_data_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
            st_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            ld_data_o = {{16{sgn_i & half_sel[15]}}, half_sel};
            if (off_i[1]) st_word_o[31:16] = wdata_i[15:0];
            else          st_word_o[15:0]  = wdata_i[15:0];
         end
         SZ_WORD: begin
            ld_data_o = word_i;
            st_word_o = wdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator between the core MEM stage and a word-addressed dm.
// Byte/half/word requests become dm word accesses; sub-word stores are done as
// read-modify-write; misaligned/illegal requests return resp_err without touching dm.
//   clk, rst_n            - clock, synchronous active-low reset
//   req_*                 - core request (valid/ready handshake)
//   resp_valid/rdata/err  - one-cycle completion pulse, no backpressure
//   dm_addr/rd/wr/wdata   - dm strobes (Moore decodes of state)
//   dm_rdata              - combinational dm read data
// Optional feature: define MEM_LSU_RANGE_CHK_EN to reject addresses with any bit
// set above the dm range instead of letting them alias.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int DM_AW = DM_AW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   output logic             resp_err,
   output logic [DM_AW-1:0] dm_addr,
   output logic             dm_rd,
   output logic             dm_wr,
   output logic [31:0]      dm_wdata,
   input  logic [31:0]      dm_rdata
);

   lsu_state_t        state_q,  state_d;
   logic [DM_AW+1:0]  addr_q,   addr_d;
   lsu_size_t         size_q,   size_d;
   logic              we_q,     we_d;
   logic              sgn_q,    sgn_d;
   logic [31:0]       wdata_q,  wdata_d;
   logic              err_q,    err_d;
   logic [31:0]       rdata_q,  rdata_d;
   logic [31:0]       merged_q, merged_d;

   logic              range_err;
   logic              bad_req;
   logic              word_st;
   logic [31:0]       ld_data;
   logic [31:0]       st_word;

`ifdef MEM_LSU_RANGE_CHK_EN
   assign range_err = |req_addr[31:DM_AW+2];
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:DM_AW+2];
   assign range_err      = 1'b0;
`endif

   assign bad_req = lsu_misaligned(lsu_size_t'(req_size), req_addr[1:0]) | range_err;
   assign word_st = we_q & (size_q == SZ_WORD);

   lsu_align u_align (
      .word_i    (dm_rdata),
      .wdata_i   (wdata_q),
      .off_i     (addr_q[1:0]),
      .size_i    (size_q),
      .sgn_i     (sgn_q),
      .ld_data_o (ld_data),
      .st_word_o (st_word)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      we_d     = we_q;
      sgn_d    = sgn_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      merged_d = merged_q;
      case (state_q)
         IDLE: if (req_valid) begin
            addr_d  = req_addr[DM_AW+1:0];
            size_d  = lsu_size_t'(req_size);
            we_d    = req_we;
            sgn_d   = req_signed;
            wdata_d = req_wdata;
            err_d   = bad_req;
            rdata_d = '0;
            state_d = bad_req ? RESP : ACCESS;
         end
         ACCESS: begin
            if (!we_q) begin
               rdata_d = ld_data;
               state_d = RESP;
            end else if (word_st) begin
               state_d = RESP;
            end else begin
               merged_d = st_word;
               state_d  = WRITE;
            end
         end
         WRITE:   state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         size_q   <= SZ_BYTE;
         we_q     <= 1'b0;
         sgn_q    <= 1'b0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         merged_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         we_q     <= we_d;
         sgn_q    <= sgn_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         merged_q <= merged_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = (state_q == RESP) & err_q;
   assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
   assign dm_addr    = addr_q[DM_AW+1:2];

   // Strobes are gated by rst_n so a reset landing mid-RMW never commits a write.
   assign dm_rd    = rst_n & (state_q == ACCESS) & ~word_st;
   assign dm_wr    = rst_n & (((state_q == ACCESS) & word_st) | (state_q == WRITE));
   assign dm_wdata = (state_q == WRITE)              ? merged_q :
                     ((state_q == ACCESS) & word_st) ? wdata_q  : '0;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [6:0]  dm_addr;
   logic        dm_rd, dm_wr;
   logic [31:0] dm_wdata, dm_rdata;

   logic [31:0] mem [0:127];

   mem_lsu #(.DM_AW(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   assign dm_rdata = mem[dm_addr];
   always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

   int pcnt = 0;
   always @(posedge clk) pcnt <= pcnt + 1;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          edge_no;
      string       name;
   } exp_t;
   exp_t sbq[$];

   int n_chk  = 0;
   int n_fail = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   // strobe activity log
   int          rd_cnt = 0, wr_cnt = 0;
   logic [6:0]  last_rd_addr = '0, last_wr_addr = '0;
   logic [31:0] last_wdata = '0;

   // monitor: pops the scoreboard on every resp_valid
   always @(negedge clk) begin
      if (dm_rd) begin rd_cnt++; last_rd_addr = dm_addr; end
      if (dm_wr) begin wr_cnt++; last_wr_addr = dm_addr; last_wdata = dm_wdata; end
      if (dm_rd && dm_wr) begin
         n_chk++; n_fail++;
         $display("FAIL strobe_excl: dm_rd and dm_wr both high at edge %0d", pcnt);
      end
      if (resp_valid) begin
         if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_resp: resp_valid at edge %0d with nothing outstanding", pcnt);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, "_err"},   {31'd0, resp_err}, {31'd0, e.err});
            chk({e.name, "_rdata"}, resp_rdata, e.rdata);
            chk({e.name, "_lat"},   pcnt, e.edge_no);
         end
      end
   end

   task automatic issue(input string name, input logic we, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd, input int lat);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) begin
         n_chk++; n_fail++;
         $display("FAIL %s_ready_timeout: req_ready=0 expected 1", name);
         return;
      end
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      e.err = exp_err; e.rdata = exp_rd; e.edge_no = pcnt + lat - 1; e.name = name;
      sbq.push_back(e);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sbq.size() != 0 || !req_ready) && n < 30) begin @(negedge clk); n++; end
      chk({name, "_drain"}, sbq.size(), 0);
   endtask

   int rd0, wr0;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[4] = 32'hDEADBEEF;
      mem[5] = 32'hAAAABBBB;
      mem[6] = 32'h11223344;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready",  {31'd0, req_ready},  32'd1);
      chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rerr",   {31'd0, resp_err},   32'd0);
      chk("rst_dmrd",   {31'd0, dm_rd},      32'd0);
      chk("rst_dmwr",   {31'd0, dm_wr},      32'd0);
      chk("rst_rdata",  resp_rdata,          32'd0);
      chk("rst_dmaddr", {25'd0, dm_addr},    32'd0);
      chk("rst_wdata",  dm_wdata,            32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // word load
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue("ldw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
      drain("ldw");
      chk("ldw_rdcnt", rd_cnt - rd0, 1);
      chk("ldw_wrcnt", wr_cnt - wr0, 0);
      chk("ldw_addr",  {25'd0, last_rd_addr}, 32'd4);

      // word store sets up the byte-load pattern
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue("stw", 1'b1, 2'b10, 1'b1, 32'h10, 32'h12F45678, 1'b0, 32'h0, 2);
      drain("stw");
      chk("stw_rdcnt", rd_cnt - rd0, 0);
      chk("stw_mem4",  mem[4], 32'h12F45678);

      // byte loads, signed and unsigned
      issue("ldb_s", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFFFF4, 2);
      issue("ldb_u", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'h000000F4, 2);
      issue("ldb_s0", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'h00000078, 2);
      drain("ldb");

      // halfword RMW store
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue("sth", 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234, 1'b0, 32'h0, 3);
      drain("sth");
      chk("sth_rdcnt", rd_cnt - rd0, 1);
      chk("sth_wrcnt", wr_cnt - wr0, 1);
      chk("sth_waddr", {25'd0, last_wr_addr}, 32'd5);
      chk("sth_wdata", last_wdata, 32'h1234BBBB);
      chk("sth_mem5",  mem[5], 32'h1234BBBB);

      // word store then half loads and a byte RMW at lane 1
      issue("stw7",  1'b1, 2'b10, 1'b0, 32'h1C, 32'hCAFEF00D, 1'b0, 32'h0, 2);
      issue("ldh_s", 1'b0, 2'b01, 1'b1, 32'h1E, 32'h0, 1'b0, 32'hFFFFCAFE, 2);
      issue("ldh_u", 1'b0, 2'b01, 1'b0, 32'h1C, 32'h0, 1'b0, 32'h0000F00D, 2);
      issue("stb",   1'b1, 2'b00, 1'b0, 32'h1D, 32'h0000005A, 1'b0, 32'h0, 3);
      drain("mix");
      chk("stb_mem7", mem[7], 32'hCAFE5A0D);

      // misaligned / illegal: no dm traffic, memory unchanged
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue("mis_w", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1);
      issue("mis_h", 1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 1'b1, 32'h0, 1);
      issue("ill",   1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1);
      drain("mis");
      chk("mis_rdcnt", rd_cnt - rd0, 0);
      chk("mis_wrcnt", wr_cnt - wr0, 0);
      chk("mis_mem4",  mem[4], 32'h12F45678);

      // reset during WRITE of a byte store
      wr0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h19; req_wdata = 32'hAB;
      @(posedge clk); #1 req_valid = 1'b0;   // accepted -> ACCESS
      @(posedge clk); #1 rst_n = 1'b0;       // now in WRITE
      @(negedge clk);
      chk("mid_dmwr",   {31'd0, dm_wr},      32'd0);
      chk("mid_rvalid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_ready", {31'd0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      chk("mid_wrcnt", wr_cnt - wr0, 0);
      chk("mid_mem6",  mem[6], 32'h11223344);

      // out-of-range address
`ifdef MEM_LSU_RANGE_CHK_EN
      issue("rng", 1'b0, 2'b10, 1'b0, 32'h210, 32'h0, 1'b1, 32'h0, 1);
`else
      issue("rng", 1'b0, 2'b10, 1'b0, 32'h210, 32'h0, 1'b0, 32'h12F45678, 2);
`endif
      drain("rng");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
